// File: rtl/tage_pkg.sv
// Shared types and widths for the TAGE update scheduler.
package tage_pkg;

  localparam int TAGE_PC_W   = 32;
  localparam int TAGE_PRED_W = 2;

  // One resolved-branch update as it travels from a source into tage_top.
  typedef struct packed {
    logic [TAGE_PC_W-1:0]   pc;
    logic                   taken;
    logic [TAGE_PRED_W-1:0] pred;
  } tage_upd_t;

endpackage

// File: rtl/tage_upd_fifo.sv
// Circular update buffer with two ordered write ports, one read port and flush.
module tage_upd_fifo
  import tage_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [1:0]       wr_cnt_i,
  input  tage_upd_t        wr0_data_i,
  input  tage_upd_t        wr1_data_i,
  input  logic             pop_i,
  output tage_upd_t        head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  tage_upd_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and count update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(wr_cnt_i);
    rdPtr_d = rdPtr_q + PTR_W'(pop_i);
    count_d = count_q + CNT_W'(wr_cnt_i) - CNT_W'(pop_i);
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end
  end

  // Control registers; flush empties the buffer exactly like reset does.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage writes: first port lands at the tail, second port right behind it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (wr_cnt_i != 2'd0) mem_q[wrPtr_q] <= wr0_data_i;
      if (wr_cnt_i == 2'd2) mem_q[wrPtr_q + PTR_W'(1)] <= wr1_data_i;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tage_update_sched.sv
// Arbitrates two branch-resolution sources into the single TAGE update port
// and generates the periodic useful-counter aging strobe.
module tage_update_sched
  import tage_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int AGE_PERIOD = 256,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req0_valid_i,
  output logic                   req0_ready_o,
  input  logic [TAGE_PC_W-1:0]   req0_pc_i,
  input  logic                   req0_taken_i,
  input  logic [TAGE_PRED_W-1:0] req0_pred_i,
  input  logic                   req1_valid_i,
  output logic                   req1_ready_o,
  input  logic [TAGE_PC_W-1:0]   req1_pc_i,
  input  logic                   req1_taken_i,
  input  logic [TAGE_PRED_W-1:0] req1_pred_i,
  input  logic                   flush_i,
  input  logic                   update_stall_i,
  output logic                   update_valid_o,
  output logic [TAGE_PC_W-1:0]   update_pc_o,
  output logic                   update_taken_o,
  output logic [TAGE_PRED_W-1:0] update_pred_o,
  output logic                   age_pulse_o,
  output logic [CNT_W-1:0]       occupancy_o
);

  localparam int               AGE_W    = $clog2(AGE_PERIOD);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_PERIOD - 1);

  logic             rr_q, rr_d;
  logic [AGE_W-1:0] ageCnt_q, ageCnt_d;
  logic             agePulse_q, agePulse_d;
  logic [CNT_W-1:0] count, free;
  logic             headValid, fire0, fire1, pop;
  logic [1:0]       wrCnt;
  tage_upd_t        req0Upd, req1Upd, wrData0, wrData1, head;

  assign req0Upd = '{pc: req0_pc_i, taken: req0_taken_i, pred: req0_pred_i};
  assign req1Upd = '{pc: req1_pc_i, taken: req1_taken_i, pred: req1_pred_i};

  // Readies depend only on registered state, so no source valid can loop back.
  assign free         = DEPTH_C - count;
  assign req0_ready_o = (free >= CNT_W'(2)) | ((free == CNT_W'(1)) & ~rr_q);
  assign req1_ready_o = (free >= CNT_W'(2)) | ((free == CNT_W'(1)) &  rr_q);

  assign fire0     = req0_valid_i & req0_ready_o & ~flush_i;
  assign fire1     = req1_valid_i & req1_ready_o & ~flush_i;
  assign headValid = (count != '0);
  assign pop       = headValid & ~update_stall_i & ~flush_i;

  // Order accepted writes (favoured source first) and advance the round-robin pointer.
  always_comb begin
    wrCnt   = 2'd0;
    wrData0 = req0Upd;
    wrData1 = req1Upd;
    rr_d    = rr_q;
    if (fire0 && fire1) begin
      wrCnt = 2'd2;
      if (rr_q) begin
        wrData0 = req1Upd;
        wrData1 = req0Upd;
      end
    end else if (fire0) begin
      wrCnt = 2'd1;
    end else if (fire1) begin
      wrCnt   = 2'd1;
      wrData0 = req1Upd;
    end
    if (flush_i) begin
      rr_d = 1'b0;
    end else if ((!rr_q && fire0) || (rr_q && fire1)) begin
      rr_d = ~rr_q;
    end
  end

  // Count committed updates and strobe aging once every AGE_PERIOD of them.
  always_comb begin
    ageCnt_d   = ageCnt_q;
    agePulse_d = 1'b0;
    if (pop) begin
      if (ageCnt_q == AGE_LAST) begin
        ageCnt_d   = '0;
        agePulse_d = 1'b1;
      end else begin
        ageCnt_d = ageCnt_q + AGE_W'(1);
      end
    end
  end

  // Arbiter and aging state; the aging count deliberately survives a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= 1'b0;
      ageCnt_q   <= '0;
      agePulse_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      ageCnt_q   <= ageCnt_d;
      agePulse_q <= agePulse_d;
    end
  end

  tage_upd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .wr_cnt_i   (wrCnt),
    .wr0_data_i (wrData0),
    .wr1_data_i (wrData1),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign update_valid_o = headValid;
  assign update_pc_o    = headValid ? head.pc    : '0;
  assign update_taken_o = headValid ? head.taken : 1'b0;
  assign update_pred_o  = headValid ? head.pred  : '0;
  assign age_pulse_o    = agePulse_q;
  assign occupancy_o    = count;

endmodule

// File: tb/tb_tage_update_sched.sv
// Directed bench for tage_update_sched (DEPTH=8, AGE_PERIOD=4).
module tb_tage_update_sched;

  logic        clk;
  logic        rst;
  logic        req0Valid, req0Ready, req0Taken;
  logic [31:0] req0Pc;
  logic [1:0]  req0Pred;
  logic        req1Valid, req1Ready, req1Taken;
  logic [31:0] req1Pc;
  logic [1:0]  req1Pred;
  logic        flush, stall;
  logic        updValid, updTaken, agePulse;
  logic [31:0] updPc;
  logic [1:0]  updPred;
  logic [3:0]  occupancy;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] drainPc    [8];
  logic        drainTaken [8];

  tage_update_sched #(
    .DEPTH      (8),
    .AGE_PERIOD (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req0_valid_i   (req0Valid),
    .req0_ready_o   (req0Ready),
    .req0_pc_i      (req0Pc),
    .req0_taken_i   (req0Taken),
    .req0_pred_i    (req0Pred),
    .req1_valid_i   (req1Valid),
    .req1_ready_o   (req1Ready),
    .req1_pc_i      (req1Pc),
    .req1_taken_i   (req1Taken),
    .req1_pred_i    (req1Pred),
    .flush_i        (flush),
    .update_stall_i (stall),
    .update_valid_o (updValid),
    .update_pc_o    (updPc),
    .update_taken_o (updTaken),
    .update_pred_o  (updPred),
    .age_pulse_o    (agePulse),
    .occupancy_o    (occupancy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive both source request channels at once.
  task automatic applyStimulus(input logic v0, input logic [31:0] pc0, input logic t0,
                               input logic [1:0] p0, input logic v1, input logic [31:0] pc1,
                               input logic t1, input logic [1:0] p1);
    req0Valid = v0; req0Pc = pc0; req0Taken = t0; req0Pred = p0;
    req1Valid = v1; req1Pc = pc1; req1Taken = t1; req1Pred = p1;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    drainPc[0] = 32'hA00; drainTaken[0] = 1'b1;
    drainPc[1] = 32'hA04; drainTaken[1] = 1'b1;
    drainPc[2] = 32'hB04; drainTaken[2] = 1'b0;
    drainPc[3] = 32'hB08; drainTaken[3] = 1'b0;
    drainPc[4] = 32'hA08; drainTaken[4] = 1'b1;
    drainPc[5] = 32'hA0C; drainTaken[5] = 1'b1;
    drainPc[6] = 32'hB0C; drainTaken[6] = 1'b0;
    drainPc[7] = 32'hD00; drainTaken[7] = 1'b0;

    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_occ", occupancy, 0);
    checkOutput("rst_valid", updValid, 0);
    checkOutput("rst_pc", updPc, 0);
    checkOutput("rst_age", agePulse, 0);
    checkOutput("rst_rdy0", req0Ready, 1);
    checkOutput("rst_rdy1", req1Ready, 1);

    $display("[TB] single update latency");
    applyStimulus(1, 32'h100, 1, 2'd2, 0, 0, 0, 0);
    tick();
    checkOutput("t1_valid", updValid, 1);
    checkOutput("t1_pc", updPc, 32'h100);
    checkOutput("t1_taken", updTaken, 1);
    checkOutput("t1_pred", updPred, 2);
    checkOutput("t1_occ1", occupancy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t1_occ0", occupancy, 0);
    checkOutput("t1_valid0", updValid, 0);

    $display("[TB] fill under stall");
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'hA00 + 32'(4 * k), 1, 2'd1, 1, 32'hB00 + 32'(4 * k), 0, 2'd3);
      tick();
      checkOutput("t2_occ", occupancy, 32'(2 * (k + 1)));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t2_rdy0_full", req0Ready, 0);
    checkOutput("t2_rdy1_full", req1Ready, 0);
    checkOutput("t2_head_pc", updPc, 32'hB00);
    checkOutput("t2_head_taken", updTaken, 0);
    checkOutput("t2_head_pred", updPred, 3);

    $display("[TB] one slot left, rr favours source 1");
    stall = 1'b0;
    tick();
    checkOutput("t3_occ7", occupancy, 7);
    checkOutput("t3_head", updPc, 32'hA00);
    stall = 1'b1;
    applyStimulus(1, 32'hC00, 1, 2'd0, 1, 32'hD00, 0, 2'd1);
    #1;
    checkOutput("t3_rdy0", req0Ready, 0);
    checkOutput("t3_rdy1", req1Ready, 1);
    tick();
    checkOutput("t3_occ8", occupancy, 8);
    checkOutput("t3_rdy0_full", req0Ready, 0);
    checkOutput("t3_rdy1_full", req1Ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] stall holds head");
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t4_pc", updPc, 32'hA00);
      checkOutput("t4_valid", updValid, 1);
      checkOutput("t4_occ", occupancy, 8);
      checkOutput("t4_age", agePulse, 0);
    end

    $display("[TB] drain in enqueue order");
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_drain_pc", updPc, drainPc[i]);
      checkOutput("t2_drain_taken", updTaken, drainTaken[i]);
      tick();
      checkOutput("t5_drain_age", agePulse, (i == 1 || i == 5) ? 1 : 0);
    end
    checkOutput("t2_drain_occ", occupancy, 0);
    checkOutput("t2_drain_valid", updValid, 0);

    $display("[TB] streaming updates and aging");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 32'h300 + 32'(4 * k), 0, 2'd1, 0, 0, 0, 0);
      tick();
      checkOutput("t5_occ", occupancy, 1);
      checkOutput("t5_age", agePulse, (k == 2 || k == 6) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t5_occ0", occupancy, 0);
    checkOutput("t5_age_end", agePulse, 0);

    $display("[TB] flush with queued entries");
    stall = 1'b1;
    applyStimulus(1, 32'h500, 0, 0, 1, 32'h504, 0, 0);
    tick();
    applyStimulus(1, 32'h508, 0, 0, 1, 32'h50C, 0, 0);
    tick();
    applyStimulus(1, 32'h510, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t6_occ5", occupancy, 5);
    applyStimulus(1, 32'h5FF, 1, 2'd3, 0, 0, 0, 0);
    flush = 1'b1;
    #1;
    checkOutput("t6_rdy0_preflush", req0Ready, 1);
    tick();
    checkOutput("t6_occ_flushed", occupancy, 0);
    checkOutput("t6_valid_flushed", updValid, 0);
    checkOutput("t6_pc_flushed", updPc, 0);
    flush = 1'b0; stall = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t6_req0_absent", occupancy, 0);
    applyStimulus(1, 32'h600, 0, 0, 1, 32'h700, 1, 0);
    tick();
    checkOutput("t6_rr_reset_occ", occupancy, 2);
    checkOutput("t6_rr_reset_head", updPc, 32'h600);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t6_second_head", updPc, 32'h700);
    checkOutput("t6_age_kept0", agePulse, 0);
    tick();
    checkOutput("t6_age_kept1", agePulse, 1);
    checkOutput("t6_empty", occupancy, 0);

    $display("[TB] reset while full");
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h800 + 32'(k), 1, 2'd2, 1, 32'h900 + 32'(k), 1, 2'd1);
      tick();
    end
    checkOutput("t7_occ_full", occupancy, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    checkOutput("t7_occ", occupancy, 0);
    checkOutput("t7_valid", updValid, 0);
    checkOutput("t7_pc", updPc, 0);
    checkOutput("t7_taken", updTaken, 0);
    checkOutput("t7_pred", updPred, 0);
    checkOutput("t7_age", agePulse, 0);
    checkOutput("t7_rdy0", req0Ready, 1);
    checkOutput("t7_rdy1", req1Ready, 1);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
